alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
Parametrised sequential successor to the per-thread 8-bit combinational ALU. Performs ADD/SUB/MUL/DIV/CMP on WIDTH-bit unsigned operands behind a valid/ready handshake. ADD, SUB and CMP complete in a single cycle. MUL (shift-add) and DIV (restoring) are iterative, one bit per cycle, which removes the array multiplier and array divider from the thread datapath. Sits between the decoder/register file and the writeback mux in each thread lane.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present on op/rs/rt.
- in_ready  output  1  block can accept a request this cycle.
- op  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 CMP, 101–111 illegal.
- rs  input  WIDTH  operand A.
- rt  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- div_by_zero  output  1  DIV issued with rt==0; qualified by out_valid.
- illegal_op  output  1  op was 101–111; qualified by out_valid.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, div_by_zero=0, illegal_op=0. Iteration registers cleared.
- Reset mid-operation: any in-flight MUL/DIV or held result is discarded; no out_valid is produced for it.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). Accept occurs when in_valid && in_ready; op/rs/rt are captured in that cycle.
- IDLE → DONE on accept of ADD, SUB, CMP or an illegal op. Result registered, so out_valid rises the cycle after accept (latency 1).
- IDLE → BUSY on accept of MUL, or of DIV with rt≠0. Counter loaded with WIDTH.
  - Each BUSY cycle performs one iteration and decrements the counter.
  - BUSY → DONE when the counter reaches 0. out_valid rises exactly WIDTH+1 cycles after the accept cycle.
- DIV with rt==0: IDLE → DONE directly (latency 1), result = all ones, div_by_zero=1.
- DONE: result and flags held stable while out_valid=1 && out_ready=0.
  - DONE → IDLE on out_ready. out_valid drops and in_ready rises the next cycle.
  - No new accept is possible in the DONE cycle. Back-to-back single-cycle ops therefore issue at most every 2 cycles.
- Arithmetic (all unsigned, modulo 2^WIDTH):
  - ADD = rs+rt, carry discarded.
  - SUB = rs−rt, borrow discarded; wraps, e.g. 3−5 = 2^WIDTH−2.
  - MUL = low WIDTH bits of rs*rt; upper half discarded.
  - DIV = floor(rs/rt); remainder not output.
  - CMP = {zeros, gt, eq, lt} in bits [2:0], comparing rs against rt unsigned; upper bits 0.
- Flags: illegal_op=1 with result=0 for op 101–111. Both flags are 0 for every legal non-div-by-zero result.
- Inputs are ignored while in_ready=0. Operand changes during BUSY do not affect the result.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings (ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_CMP);
  - FSM state encodings;
  - CMP flag bit positions (CMP_GT=2, CMP_EQ=1, CMP_LT=0).
- One sub-module, alu_iter_step: combinational single-iteration datapath.
  - MUL mode: conditional add of multiplicand, then shift.
  - DIV mode: trial subtract/restore, produce quotient bit.
  - The top instantiates it once and owns the FSM, counter and registers.

Test Plan (WIDTH=8 unless stated):
- ADD 200+100, out_ready=1 → out_valid one cycle after accept, result=44, flags 0. SUB 3−5 → result=254.
- MUL 13*11 → out_valid exactly 9 cycles after accept, result=143. MUL 255*255 → result=1. in_ready=0 throughout BUSY/DONE.
- DIV 200/7 → result=28 at accept+9. DIV 5/0 → out_valid at accept+1, result=255, div_by_zero=1.
- CMP 9 vs 9 → result=0x02. CMP 10 vs 3 → 0x04. CMP 3 vs 10 → 0x01. op=110 → result=0, illegal_op=1.
- Backpressure: MUL 6*7 with out_ready=0 for 5 cycles after out_valid → result=42 held stable. Drop happens one cycle after out_ready=1. Operands toggled during BUSY do not change the result.
- Assert reset during BUSY of DIV 100/3 → next cycle: out_valid=0, in_ready=1; a following ADD 1+1 returns 2. Repeat MUL 15*15 with WIDTH=16 → result=225 at accept+17.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op encodings, FSM states and
// CMP flag bit positions.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } alu_state_e;

  localparam int unsigned CMP_GT = 2;
  localparam int unsigned CMP_EQ = 1;
  localparam int unsigned CMP_LT = 0;

endpackage

// File: rtl/alu_iter_step.sv
// One iteration of the shared MUL/DIV datapath (purely combinational).
// Ports:
//   div_mode_i  0: shift-add multiply step, 1: restoring divide step
//   acc_i/o     MUL: partial product        DIV: partial remainder
//   sh_i/o      MUL: shifted multiplicand   DIV: dividend shifting out, quotient shifting in
//   opb_i/o     MUL: remaining multiplier   DIV: divisor (passed through)
module alu_iter_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             div_mode_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] sh_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] sh_o,
  output logic [WIDTH-1:0] opb_o
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  always_comb begin
    // Remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
    rem_shift = {acc_i, sh_i[WIDTH-1]};
    diff      = rem_shift - {1'b0, opb_i};
    if (div_mode_i) begin
      // diff[WIDTH] set means the trial subtract borrowed: restore.
      if (!diff[WIDTH]) begin
        acc_o = diff[WIDTH-1:0];
        sh_o  = {sh_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = rem_shift[WIDTH-1:0];
        sh_o  = {sh_i[WIDTH-2:0], 1'b0};
      end
      opb_o = opb_i;
    end else begin
      acc_o = opb_i[0] ? (acc_i + sh_i) : acc_i;
      sh_o  = sh_i << 1;
      opb_o = opb_i >> 1;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Sequential ALU with valid/ready handshake. ADD/SUB/CMP/illegal/div-by-zero
// finish with latency 1; MUL and DIV iterate one bit per cycle (latency WIDTH+1).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_ready       request handshake; op/rs/rt captured on accept
//   out_valid/out_ready     result handshake; result and flags held until taken
//   result                  WIDTH-bit result
//   div_by_zero, illegal_op status flags qualified by out_valid
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  alu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] step_acc, step_sh, step_opb;

  alu_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_mode_i(div_q),
    .acc_i     (acc_q),
    .sh_i      (sh_q),
    .opb_i     (opb_q),
    .acc_o     (step_acc),
    .sh_o      (step_sh),
    .opb_o     (step_opb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opb_d    = opb_q;
    div_d    = div_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          result_d = '0;
          dbz_d    = 1'b0;
          ill_d    = 1'b0;
          state_d  = StDone;
          case (op)
            ALU_ADD: result_d = rs + rt;
            ALU_SUB: result_d = rs - rt;
            ALU_CMP: begin
              result_d[CMP_GT] = rs > rt;
              result_d[CMP_EQ] = rs == rt;
              result_d[CMP_LT] = rs < rt;
            end
            ALU_MUL, ALU_DIV: begin
              if (op == ALU_DIV && rt == '0) begin
                result_d = '1;
                dbz_d    = 1'b1;
              end else begin
                acc_d   = '0;
                sh_d    = rs;
                opb_d   = rt;
                div_d   = (op == ALU_DIV);
                cnt_d   = CNT_W'(WIDTH);
                state_d = StBusy;
              end
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
      StBusy: begin
        acc_d = step_acc;
        sh_d  = step_sh;
        opb_d = step_opb;
        cnt_d = cnt_q - 1'b1;
        // Last iteration: capture the finished value straight from the step logic.
        if (cnt_q == CNT_W'(1)) begin
          result_d = div_q ? step_sh : step_acc;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opb_q    <= '0;
      div_q    <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opb_q    <= opb_d;
      div_q    <= div_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, div_by_zero, illegal_op;
  logic [2:0]  op;
  logic [7:0]  rs, rt, result;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, dbz16, ill16;
  logic [2:0]  op16;
  logic [15:0] rs16, rt16, result16;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0]  res;
    logic        dbz;
    logic        ill;
    int unsigned lat;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_by_zero(div_by_zero),
    .illegal_op (illegal_op)
  );

  alu_multicycle #(.WIDTH(16)) dut16 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid16),
    .in_ready   (in_ready16),
    .op         (op16),
    .rs         (rs16),
    .rt         (rt16),
    .out_valid  (out_valid16),
    .out_ready  (out_ready16),
    .result     (result16),
    .div_by_zero(dbz16),
    .illegal_op (ill16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model of an 8-bit operation.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t   e;
    logic [15:0] prod;
    e = '{res: 8'd0, dbz: 1'b0, ill: 1'b0, lat: 1};
    case (o)
      3'b000: e.res = a + b;
      3'b001: e.res = a - b;
      3'b010: begin
        prod  = 16'(a) * 16'(b);
        e.res = prod[7:0];
        e.lat = 9;
      end
      3'b011: begin
        if (b == 8'd0) begin
          e.res = 8'hff;
          e.dbz = 1'b1;
        end else begin
          e.res = a / b;
          e.lat = 9;
        end
      end
      3'b100: e.res = {5'd0, a > b, a == b, a < b};
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input int hold);
    exp_t e;
    int   cyc;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    op        = o;
    rs        = a;
    rt        = b;
    out_ready = (hold == 0);
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    cyc = 1;
    // Junk on the inputs while busy must be ignored.
    while (!out_valid && cyc < 100) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      op       = 3'($urandom_range(0, 7));
      rs       = 8'($urandom);
      rt       = 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    check("out_valid_seen", 32'(out_valid), 32'd1);
    check("latency", 32'(cyc), e.lat);
    check("result", 32'(result), 32'(e.res));
    check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
    check("illegal_op", 32'(illegal_op), 32'(e.ill));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'(e.res));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("drop_valid", 32'(out_valid), 32'd0);
    check("drop_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    reset       = 1'b1;
    in_valid    = 1'b0;
    op          = 3'd0;
    rs          = 8'd0;
    rt          = 8'd0;
    out_ready   = 1'b0;
    in_valid16  = 1'b0;
    op16        = 3'd0;
    rs16        = 16'd0;
    rt16        = 16'd0;
    out_ready16 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_ill", 32'(illegal_op), 32'd0);
    reset = 1'b0;

    run_op(ALU_ADD, 8'd200, 8'd100, 0);
    run_op(ALU_SUB, 8'd3,   8'd5,   0);
    run_op(ALU_MUL, 8'd13,  8'd11,  0);
    run_op(ALU_MUL, 8'd255, 8'd255, 0);
    run_op(ALU_DIV, 8'd200, 8'd7,   0);
    run_op(ALU_DIV, 8'd5,   8'd0,   0);
    run_op(ALU_CMP, 8'd9,   8'd9,   0);
    run_op(ALU_CMP, 8'd10,  8'd3,   0);
    run_op(ALU_CMP, 8'd3,   8'd10,  0);
    run_op(3'b110,  8'd77,  8'd12,  0);
    run_op(ALU_MUL, 8'd6,   8'd7,   5);
    run_op(ALU_DIV, 8'd255, 8'd1,   2);
    run_op(ALU_DIV, 8'd7,   8'd200, 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    in_valid = 1'b1;
    op       = ALU_DIV;
    rs       = 8'd100;
    rt       = 8'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_reset", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (12) begin
      @(negedge clk);
      check("no_stale_valid", 32'(out_valid), 32'd0);
    end
    run_op(ALU_ADD, 8'd1, 8'd1, 0);

    // WIDTH=16 multiply.
    @(negedge clk);
    in_valid16  = 1'b1;
    op16        = ALU_MUL;
    rs16        = 16'd15;
    rt16        = 16'd15;
    out_ready16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    cyc = 1;
    while (!out_valid16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("w16_valid", 32'(out_valid16), 32'd1);
    check("w16_latency", 32'(cyc), 32'd17);
    check("w16_result", 32'(result16), 32'd225);
    check("w16_flags", {30'd0, dbz16, ill16}, 32'd0);
    @(negedge clk);
    check("w16_drop", 32'(out_valid16), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
